// File: rtl/current_averager_pkg.sv
// Shared register map, control/status bit positions and FSM state type
// for the current moving-average block.
package current_averager_pkg;

    localparam logic [2:0] ADDR_AVG    = 3'd0;
    localparam logic [2:0] ADDR_MAX    = 3'd1;
    localparam logic [2:0] ADDR_MIN    = 3'd2;
    localparam logic [2:0] ADDR_COUNT  = 3'd3;
    localparam logic [2:0] ADDR_THR    = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int CTRL_CLEAR_BIT  = 0;
    localparam int CTRL_ENABLE_BIT = 1;
    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_OVC_BIT    = 1;

    localparam logic [31:0] THRESHOLD_RESET = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sample_ring.sv
// Circular sample window: exposes the slot about to be overwritten so the
// running sum can subtract it in the same cycle the new sample is added.
module sample_ring #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LOG2_WINDOW  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic                    clear_i,
    input  logic [SAMPLE_WIDTH-1:0] data_i,
    output logic [SAMPLE_WIDTH-1:0] old_o
);

    localparam int DEPTH = 1 << LOG2_WINDOW;

    logic [SAMPLE_WIDTH-1:0] ring_q [DEPTH];
    logic [LOG2_WINDOW-1:0]  wptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            wptr_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
            wptr_q <= '0;
        end else if (wr_en_i) begin
            ring_q[wptr_q] <= data_i;
            wptr_q         <= wptr_q + 1'b1;
        end
    end

    assign old_o = ring_q[wptr_q];

endmodule

// File: rtl/current_averager.sv
// Boxcar moving average of signed current samples with peak tracking,
// sticky overcurrent detection and an Avalon-MM register interface.
module current_averager
    import current_averager_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LOG2_WINDOW  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic [2:0]              address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic                    waitrequest,
    output logic [31:0]             current_average,
    output logic                    overcurrent
);

    localparam int SUM_W  = SAMPLE_WIDTH + LOG2_WINDOW;
    localparam int WINDOW = 1 << LOG2_WINDOW;

    state_t state_q, state_d;

    logic signed [SAMPLE_WIDTH-1:0] sample_s, old_s;
    logic [SAMPLE_WIDTH-1:0]        old_raw;
    logic signed [SUM_W-1:0]        sum_q, sum_d, sum_sh;
    logic signed [31:0]             avg_q, thr_q;
    logic signed [SAMPLE_WIDTH-1:0] max_q, min_q;
    logic [31:0]                    count_q, count_d;
    logic                           first_q, enable_q, enable_d, ovc_q, ovc_d;
    logic                           rd_pend_q, rd_start;
    logic [31:0]                    readdata_q, rd_mux;
    logic                           clear_wr, thr_wr, ctrl_wr, status_wr, accept;

    assign sample_s  = sample_data;
    assign old_s     = old_raw;
    assign ctrl_wr   = write && (address == ADDR_CTRL);
    assign thr_wr    = write && (address == ADDR_THR);
    assign status_wr = write && (address == ADDR_STATUS);
    assign clear_wr  = ctrl_wr && writedata[CTRL_CLEAR_BIT];
    assign enable_d  = ctrl_wr ? writedata[CTRL_ENABLE_BIT] : enable_q;
    // A clear in the same cycle as a strobe drops the sample.
    assign accept    = sample_valid && (state_q != IDLE) && !clear_wr;

    sample_ring #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .LOG2_WINDOW  (LOG2_WINDOW)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .wr_en_i (accept),
        .clear_i (clear_wr),
        .data_i  (sample_data),
        .old_o   (old_raw)
    );

    assign sum_d   = sum_q + SUM_W'(sample_s) - SUM_W'(old_s);
    assign sum_sh  = sum_q >>> LOG2_WINDOW;
    assign count_d = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    always_comb begin
        ovc_d = ovc_q;
        if (status_wr && writedata[STAT_OVC_BIT]) ovc_d = 1'b0;
        // Set after the W1C so a fresh exceed wins.
        if ((state_q == RUN) && (avg_q > thr_q)) ovc_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_d) begin
            state_d = IDLE;
        end else if (clear_wr) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE:    state_d = (count_q >= 32'(WINDOW)) ? RUN : FILL;
                FILL:    if (accept && (count_q >= 32'(WINDOW - 1))) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q    <= '0;
            avg_q    <= '0;
            count_q  <= '0;
            max_q    <= '0;
            min_q    <= '0;
            first_q  <= 1'b1;
            enable_q <= 1'b1;
            thr_q    <= THRESHOLD_RESET;
            ovc_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            ovc_q    <= ovc_d;
            if (thr_wr) thr_q <= writedata;
            if (clear_wr) begin
                sum_q   <= '0;
                avg_q   <= '0;
                count_q <= '0;
                max_q   <= '0;
                min_q   <= '0;
                first_q <= 1'b1;
            end else begin
                avg_q <= 32'(sum_sh);
                if (accept) begin
                    sum_q   <= sum_d;
                    count_q <= count_d;
                    first_q <= 1'b0;
                    if (first_q || (sample_s > max_q)) max_q <= sample_s;
                    if (first_q || (sample_s < min_q)) min_q <= sample_s;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_AVG:    rd_mux = avg_q;
            ADDR_MAX:    rd_mux = 32'(max_q);
            ADDR_MIN:    rd_mux = 32'(min_q);
            ADDR_COUNT:  rd_mux = count_q;
            ADDR_THR:    rd_mux = thr_q;
            ADDR_CTRL:   rd_mux[CTRL_ENABLE_BIT] = enable_q;
            ADDR_STATUS: begin
                rd_mux[STAT_FULL_BIT] = (state_q == RUN);
                rd_mux[STAT_OVC_BIT]  = ovc_q;
            end
            default:     rd_mux = '0;
        endcase
    end

    // First read cycle captures data and stalls; the second completes.
    assign rd_start = read && !rd_pend_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            rd_pend_q <= rd_start;
            if (rd_start) readdata_q <= rd_mux;
        end
    end

    assign waitrequest     = rd_start && !reset;
    assign readdata        = readdata_q;
    assign current_average = avg_q;
    assign overcurrent     = ovc_q;

endmodule

// File: tb/tb_current_averager.sv
// Directed bench for current_averager: averaging, wrap, peaks, overcurrent,
// clear collisions, enable gating and the Avalon read handshake.
module tb_current_averager;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic [2:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] current_average;
    logic        overcurrent;

    int checks = 0;
    int errors = 0;

    current_averager #(.SAMPLE_WIDTH(16), .LOG2_WINDOW(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .address         (address),
        .write           (write),
        .writedata       (writedata),
        .read            (read),
        .readdata        (readdata),
        .waitrequest     (waitrequest),
        .current_average (current_average),
        .overcurrent     (overcurrent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        sample_valid = 1'b1;
        sample_data  = v;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        write     = 1'b1;
        address   = a;
        writedata = d;
        tick();
        write     = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        read    = 1'b1;
        address = a;
        #1;
        check({tag, "_wait1"}, {31'b0, waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_wait0"}, {31'b0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        read = 1'b0;
        check(tag, readdata, exp);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_avg", current_average, 32'd0);
        check("rst_ovc", {31'b0, overcurrent}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        check("rst_wait", {31'b0, waitrequest}, 32'd0);
        reset = 1'b0;
        tick();
        reg_read("rst_thr", 3'd4, 32'h7FFF_FFFF);
        reg_read("rst_ctrl", 3'd5, 32'h2);

        // Ramp with 16 x +100: avg after strobe k reflects the sum of k-1 samples
        for (int k = 1; k <= 16; k++) begin
            send(16'd100);
            check($sformatf("ramp_%0d", k), current_average, 32'((100 * (k - 1)) / 16));
        end
        tick();
        check("ramp_final", current_average, 32'd100);
        reg_read("fill_status", 3'd6, 32'h1);
        reg_read("fill_count", 3'd3, 32'd16);

        // Wrap: 16 x +200 replace the +100 window
        for (int k = 1; k <= 16; k++) begin
            send(16'd200);
            check($sformatf("wrap_%0d", k), current_average, 32'((1600 + 100 * (k - 1)) / 16));
        end
        tick();
        check("wrap_final", current_average, 32'd200);
        reg_read("wrap_count", 3'd3, 32'd32);
        reg_read("wrap_max", 3'd1, 32'd200);
        reg_read("wrap_min", 3'd2, 32'd100);

        // Overcurrent set, sticky, W1C, and set-wins collision
        reg_write(3'd4, 32'd150);
        check("ovc_before", {31'b0, overcurrent}, 32'd0);
        tick();
        check("ovc_set", {31'b0, overcurrent}, 32'd1);
        for (int k = 0; k < 16; k++) send(16'd0);
        tick();
        check("zero_avg", current_average, 32'd0);
        check("ovc_sticky", {31'b0, overcurrent}, 32'd1);
        reg_write(3'd6, 32'h2);
        check("ovc_w1c", {31'b0, overcurrent}, 32'd0);
        for (int k = 0; k < 16; k++) send(16'd200);
        tick();
        tick();
        check("ovc_reset", {31'b0, overcurrent}, 32'd1);
        reg_write(3'd6, 32'h2);
        check("ovc_setwins", {31'b0, overcurrent}, 32'd1);

        // Clear colliding with a sample strobe
        sample_valid = 1'b1;
        sample_data  = 16'd500;
        reg_write(3'd5, 32'h3);
        sample_valid = 1'b0;
        check("clr_avg0", current_average, 32'd0);
        tick();
        check("clr_avg1", current_average, 32'd0);
        reg_read("clr_count", 3'd3, 32'd0);
        reg_read("clr_ctrl", 3'd5, 32'h2);
        reg_read("clr_status", 3'd6, 32'h2);
        reg_read("clr_max", 3'd1, 32'd0);
        reg_read("clr_thr", 3'd4, 32'd150);

        // Floor rounding of negatives: -3,0 x8 sums to -24 -> -2
        for (int k = 0; k < 8; k++) begin
            send(16'hFFFD);
            send(16'h0000);
        end
        tick();
        check("neg_avg", current_average, 32'hFFFF_FFFE);
        reg_read("neg_max", 3'd1, 32'd0);
        reg_read("neg_min", 3'd2, 32'hFFFF_FFFD);
        reg_read("neg_reg0", 3'd0, 32'hFFFF_FFFE);

        // Enable gating
        reg_write(3'd5, 32'h0);
        for (int k = 0; k < 5; k++) send(16'd1000);
        tick();
        tick();
        check("dis_avg", current_average, 32'hFFFF_FFFE);
        reg_read("dis_count", 3'd3, 32'd16);
        reg_read("dis_status", 3'd6, 32'h2);
        reg_read("dis_ctrl", 3'd5, 32'h0);
        reg_read("reg7", 3'd7, 32'd0);

        // Reset asserted mid-read
        reg_write(3'd5, 32'h2);
        reg_read("pre_rst_avg", 3'd0, 32'hFFFF_FFFE);
        read    = 1'b1;
        address = 3'd4;
        #1;
        check("midrd_wait1", {31'b0, waitrequest}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrd_wait0", {31'b0, waitrequest}, 32'd0);
        check("midrd_avg", current_average, 32'd0);
        check("midrd_ovc", {31'b0, overcurrent}, 32'd0);
        check("midrd_rdata", readdata, 32'd0);
        read = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reg_read("post_rst_thr", 3'd4, 32'h7FFF_FFFF);
        reg_read("post_rst_count", 3'd3, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/current_averager.md
# current_averager

Moving-average stage that feeds the fan PWM controller's `current_average` input. It accepts a stream of signed ADC current samples and keeps a boxcar running sum over 2^LOG2_WINDOW samples. It drives the sign-extended 32-bit average, min/max peaks and a sticky overcurrent flag. All of these are exposed on an Avalon-MM slave, in the same register style as the fan controller.

## Interface
- `SAMPLE_WIDTH`, 16: width of signed input samples (8..24).
- `LOG2_WINDOW`, 4: log2 of the averaging window, giving 16 samples (1..8).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `sample_valid`  in  1  one-cycle strobe; the sample is consumed on this edge. There is no backpressure.
- `sample_data`  in  SAMPLE_WIDTH  signed current sample.
- `address`  in  3  Avalon register index.
- `write`  in  1  Avalon write.
- `writedata`  in  32  Avalon write data.
- `read`  in  1  Avalon read.
- `readdata`  out  32  Avalon read data.
- `waitrequest`  out  1  Avalon wait.
- `current_average`  out  32  signed average; goes to FanControl.
- `overcurrent`  out  1  latched overcurrent flag.

## Operation
- **States**
  - IDLE: enable=0. Samples are ignored.
  - FILL: enabled, with count < 2^LOG2_WINDOW.
  - RUN: enabled, with count ≥ 2^LOG2_WINDOW.
- **Transitions**
  - IDLE→FILL on enable=1.
  - FILL→RUN on the edge that accepts sample number 2^LOG2_WINDOW.
  - Any state→IDLE on enable=0. Contents are kept.
  - A clear moves the block to FILL if enabled, otherwise IDLE.
- **Accepting a sample** (FILL/RUN with `sample_valid`):
  - buffer[wptr] ← sample.
  - sum ← sum + sample − buffer[wptr] (old value).
  - wptr wraps modulo 2^LOG2_WINDOW.
  - count increments and saturates at 0xFFFFFFFF.
  - Peaks update with max/min. The first accepted sample after a reset or clear loads both peaks.
- **Sum and average**
  - The sum is signed, SAMPLE_WIDTH+LOG2_WINDOW bits wide, and cannot overflow.
  - average = sum >>> LOG2_WINDOW (arithmetic shift, floors toward −∞), sign-extended to 32 bits.
  - During FILL, empty slots hold 0, so the average ramps up.
- **Overcurrent**
  - Only evaluated in RUN.
  - If the average > threshold (signed compare), the status bit is set and stays set.
  - `overcurrent` output equals the status bit.
- **Clear**
  - Zeroes the buffer, sum, wptr, count, peaks and average in one cycle.
  - Does not touch the threshold, enable or overcurrent.
- **Simultaneous events**
  - Clear together with `sample_valid`: the clear wins and the sample is dropped.
  - Write-1-to-clear of overcurrent in the same cycle as a new exceed: set wins.
- **Registers**
  - 0 average (RO)
  - 1 peak max (RO, sign-extended)
  - 2 peak min (RO, sign-extended)
  - 3 count (RO)
  - 4 threshold (RW, signed, reset 0x7FFFFFFF)
  - 5 control: bit0 clear (write 1, self-clearing, reads 0), bit1 enable (reset 1)
  - 6 status: bit0 full (state==RUN), bit1 overcurrent (write 1 clears)
  - 7 reads 0
  - Writes to RO addresses are ignored.
- **Reset values**
  - All outputs are 0.
  - Internal state: enable=1, threshold 0x7FFFFFFF, state FILL.

## Timing
- Sample accepted at edge T: sum is updated at T.
- `current_average` and the register-0 value are updated at edge T+1, giving a latency of 2 cycles from `sample_valid` being asserted.
- `overcurrent` rises at edge T+2 at the earliest.
- **Avalon read**
  - `waitrequest`=1 combinationally in the first cycle that `read` is high.
  - `readdata` is registered on that edge.
  - `waitrequest`=0 in the next cycle, which completes the read.
  - 2 cycles per read. `readdata` holds its value until the next read.
- **Avalon write**
  - `waitrequest`=0 for writes. A write takes effect on the same edge.
  - The clear action appears on that edge, so registers read as cleared from the next cycle.
- **Reset mid-operation**: all state returns immediately to reset values. Partial reads are abandoned and `waitrequest` goes to 0.

## Structure
- Package `current_averager_pkg` holds:
  - register address localparams (ADDR_AVG..ADDR_STATUS);
  - control/status bit positions;
  - `state_t` enum {IDLE, FILL, RUN}.
- Sub-module `sample_ring`:
  - a 2^LOG2_WINDOW × SAMPLE_WIDTH register array;
  - wrapping write pointer, combinational read of the slot being overwritten;
  - synchronous bulk clear.
- Top level holds the sum, peaks, FSM and Avalon decode.

## Test plan
- **Reset then averaging:** after reset, 16 samples of +100 → `current_average` ramps 6,12,…,100 and reaches 100 two cycles after the 16th strobe. full=1, count=16.
- **Floor rounding and negatives:** 16 samples alternating −3 and 0 (sum −24) → average −2 (0xFFFFFFFE). Peaks read max 0 and min 0xFFFFFFFD.
- **Wrap-around:** window full of 100, then 16 samples of 200 → the average rises by 6 or 7 per sample and settles at 200. Count reads 32.
- **Overcurrent:**
  - threshold=150 with the average at 200 → `overcurrent`=1 and stays 1 after the samples drop to 0.
  - Writing status 0x2 → clears it.
  - A simultaneous exceed and clear-write → remains 1.
- **Clear colliding with a sample:** control write 0x3 in the same cycle as `sample_valid` → count 0, average 0, the sample is not counted, enable stays 1.
- **Avalon protocol and enable:**
  - Each read shows `waitrequest` 1 for one cycle then 0, with correct data.
  - enable=0 → samples are ignored and count is unchanged.
  - An async reset asserted mid-read drops `waitrequest` and zeroes all outputs.
